// File: rtl/t09_lcd_cmd_decoder.sv
// LCD controller command/parameter decoder: window registers, pixel format,
// display flags and a RAMWR pixel stream walking a rectangular window.
module t09_lcd_cmd_decoder #(
    parameter int COL_MAX = 239,
    parameter int ROW_MAX = 319
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        wr_en,
    input  logic [7:0]  D,
    input  logic        dcx,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_color,
    output logic        disp_on,
    output logic        sleep_out,
    output logic [7:0]  colmod,
    output logic [15:0] win_sc,
    output logic [15:0] win_ec,
    output logic [15:0] win_sp,
    output logic [15:0] win_ep,
    output logic        bad_cmd
);
    localparam logic [15:0] COL_END = 16'(COL_MAX);
    localparam logic [15:0] ROW_END = 16'(ROW_MAX);

    typedef enum logic [2:0] {IDLE, CASET, PASET, COLMOD, RAMWR} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [23:0] shadow;
    logic [7:0]  low;
    logic        phase;
    logic [8:0]  px;
    logic [8:0]  py;
    logic        x_wrap;
    logic [8:0]  nx;
    logic [8:0]  ny;

    // Equality compares only, so inverted windows still wrap deterministically
    always_comb begin
        x_wrap = (px == win_ec[8:0]);
        nx = px + 9'd1;
        ny = py;
        if (x_wrap) begin
            nx = win_sc[8:0];
            ny = (py == win_ep[8:0]) ? win_sp[8:0] : py + 9'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow    <= '0;
            low       <= '0;
            phase     <= 1'b0;
            px        <= '0;
            py        <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
            disp_on   <= 1'b0;
            sleep_out <= 1'b0;
            colmod    <= '0;
            win_sc    <= '0;
            win_ec    <= COL_END;
            win_sp    <= '0;
            win_ep    <= ROW_END;
            bad_cmd   <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            bad_cmd   <= 1'b0;
            if (wr_en && !dcx) begin
                cnt   <= '0;
                phase <= 1'b0;
                state <= IDLE;
                case (D)
                    8'h00: ;
                    8'h01: begin
                        shadow    <= '0;
                        low       <= '0;
                        px        <= '0;
                        py        <= '0;
                        pix_x     <= '0;
                        pix_y     <= '0;
                        pix_color <= '0;
                        disp_on   <= 1'b0;
                        sleep_out <= 1'b0;
                        colmod    <= '0;
                        win_sc    <= '0;
                        win_ec    <= COL_END;
                        win_sp    <= '0;
                        win_ep    <= ROW_END;
                    end
                    8'h10: sleep_out <= 1'b0;
                    8'h11: sleep_out <= 1'b1;
                    8'h28: disp_on <= 1'b0;
                    8'h29: disp_on <= 1'b1;
                    8'h2A: state <= CASET;
                    8'h2B: state <= PASET;
                    8'h3A: state <= COLMOD;
                    8'h2C: begin
                        state <= RAMWR;
                        px    <= win_sc[8:0];
                        py    <= win_sp[8:0];
                    end
                    default: bad_cmd <= 1'b1;
                endcase
            end else if (wr_en) begin
                case (state)
                    CASET, PASET: begin
                        cnt <= cnt + 2'd1;
                        case (cnt)
                            2'd0: shadow[23:16] <= D;
                            2'd1: shadow[15:8] <= D;
                            2'd2: shadow[7:0] <= D;
                            default: begin
                                state <= IDLE;
                                if (state == CASET) begin
                                    win_sc <= shadow[23:8];
                                    win_ec <= {shadow[7:0], D};
                                end else begin
                                    win_sp <= shadow[23:8];
                                    win_ep <= {shadow[7:0], D};
                                end
                            end
                        endcase
                    end
                    COLMOD: begin
                        colmod <= D;
                        state  <= IDLE;
                    end
                    RAMWR: begin
                        phase <= ~phase;
                        if (!phase) begin
                            low <= D;
                        end else begin
                            pix_valid <= 1'b1;
                            pix_x     <= px;
                            pix_y     <= py;
                            pix_color <= {D, low};
                            px        <= nx;
                            py        <= ny;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_t09_lcd_cmd_decoder.sv
// Bench for t09_lcd_cmd_decoder: reference model feeds a pixel scoreboard,
// monitor compares every output each cycle; directed scenarios plus random bytes.
module tb_t09_lcd_cmd_decoder;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  D = '0;
    logic        dcx = 1'b0;
    logic        pix_valid;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_color;
    logic        disp_on;
    logic        sleep_out;
    logic [7:0]  colmod;
    logic [15:0] win_sc;
    logic [15:0] win_ec;
    logic [15:0] win_sp;
    logic [15:0] win_ep;
    logic        bad_cmd;

    t09_lcd_cmd_decoder #(.COL_MAX(239), .ROW_MAX(319)) dut (
        .clk(clk), .nrst(nrst), .wr_en(wr_en), .D(D), .dcx(dcx),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_color(pix_color), .disp_on(disp_on), .sleep_out(sleep_out),
        .colmod(colmod), .win_sc(win_sc), .win_ec(win_ec),
        .win_sp(win_sp), .win_ep(win_ep), .bad_cmd(bad_cmd)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int c;} pix_t;

    localparam int M_IDLE = 0, M_CAS = 1, M_PAS = 2, M_COL = 3, M_RAM = 4;

    int tests = 0;
    int fails = 0;
    int bad_cnt = 0;

    // Reference model state
    int mode, low, px, py;
    int sc, ec, sp, ep;
    int m_disp, m_slp, m_col, m_bad, m_valid;
    int lx, ly, lc;
    int prm[$];
    pix_t exp_q[$];
    pix_t seen[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic m_regs();
        mode = M_IDLE; low = -1; px = 0; py = 0;
        sc = 0; ec = 239; sp = 0; ep = 319;
        m_disp = 0; m_slp = 0; m_col = 0;
        lx = 0; ly = 0; lc = 0;
        prm.delete();
    endtask

    task automatic m_step();
        pix_t p;
        m_valid = 0;
        m_bad = 0;
        if (!wr_en) return;
        if (!dcx) begin
            prm.delete();
            low = -1;
            mode = M_IDLE;
            case (D)
                8'h00: ;
                8'h01: m_regs();
                8'h10: m_slp = 0;
                8'h11: m_slp = 1;
                8'h28: m_disp = 0;
                8'h29: m_disp = 1;
                8'h2A: mode = M_CAS;
                8'h2B: mode = M_PAS;
                8'h3A: mode = M_COL;
                8'h2C: begin mode = M_RAM; px = sc % 512; py = sp % 512; end
                default: m_bad = 1;
            endcase
        end else if (mode == M_CAS || mode == M_PAS) begin
            prm.push_back(int'(D));
            if (prm.size() == 4) begin
                if (mode == M_CAS) begin
                    sc = prm[0] * 256 + prm[1]; ec = prm[2] * 256 + prm[3];
                end else begin
                    sp = prm[0] * 256 + prm[1]; ep = prm[2] * 256 + prm[3];
                end
                prm.delete();
                mode = M_IDLE;
            end
        end else if (mode == M_COL) begin
            m_col = int'(D);
            mode = M_IDLE;
        end else if (mode == M_RAM) begin
            if (low < 0) begin
                low = int'(D);
            end else begin
                p.x = px; p.y = py; p.c = int'(D) * 256 + low;
                exp_q.push_back(p);
                lx = p.x; ly = p.y; lc = p.c;
                m_valid = 1;
                low = -1;
                if (px == ec % 512) begin
                    px = sc % 512;
                    py = (py == ep % 512) ? sp % 512 : (py + 1) % 512;
                end else begin
                    px = (px + 1) % 512;
                end
            end
        end
    endtask

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_regs();
            m_valid = 0;
            m_bad = 0;
            exp_q.delete();
        end else begin
            m_step();
        end
    end

    // Monitor: scoreboard pop on every pixel, plus register comparisons
    always @(negedge clk) begin
        pix_t e;
        chk("pix_valid", 32'(pix_valid), 32'(m_valid));
        chk("bad_cmd", 32'(bad_cmd), 32'(m_bad));
        if (bad_cmd) bad_cnt++;
        if (pix_valid) begin
            pix_t s;
            s.x = int'(pix_x); s.y = int'(pix_y); s.c = int'(pix_color);
            seen.push_back(s);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_extra actual=%0h,%0h,%0h required=none",
                         pix_x, pix_y, pix_color);
            end else begin
                e = exp_q.pop_front();
                tests--;
                chk("sb_pixel", {pix_x, pix_y, pix_color[13:0]},
                    {9'(e.x), 9'(e.y), 14'(e.c)});
                chk("sb_color", 32'(pix_color), 32'(e.c));
            end
        end
        chk("pix_x", 32'(pix_x), 32'(lx));
        chk("pix_y", 32'(pix_y), 32'(ly));
        chk("pix_color", 32'(pix_color), 32'(lc));
        chk("disp_on", 32'(disp_on), 32'(m_disp));
        chk("sleep_out", 32'(sleep_out), 32'(m_slp));
        chk("colmod", 32'(colmod), 32'(m_col));
        chk("win_sc", 32'(win_sc), 32'(sc));
        chk("win_ec", 32'(win_ec), 32'(ec));
        chk("win_sp", 32'(win_sp), 32'(sp));
        chk("win_ep", 32'(win_ep), 32'(ep));
    end

    task automatic send(input logic c, input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1;
        dcx = c;
        D = b;
    endtask

    task automatic cmd(input logic [7:0] b);
        send(1'b0, b);
    endtask

    task automatic dat(input logic [7:0] b);
        send(1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            wr_en = 1'b0;
            dcx = 1'($urandom);
            D = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        idle(1);
        @(posedge clk);
        #3 nrst = 1'b0;
        repeat (2) @(posedge clk);
        #3 nrst = 1'b1;
        idle(1);
    endtask

    task automatic window(input int s0, input int e0, input int s1, input int e1);
        cmd(8'h2A);
        dat(8'(s0 >> 8)); dat(8'(s0)); dat(8'(e0 >> 8)); dat(8'(e0));
        cmd(8'h2B);
        dat(8'(s1 >> 8)); dat(8'(s1)); dat(8'(e1 >> 8)); dat(8'(e1));
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) begin
            dat(8'($urandom)); dat(8'($urandom));
        end
    endtask

    initial begin
        int r;
        logic [7:0] cmds [11];
        cmds = '{8'h2A, 8'h2B, 8'h2C, 8'h3A, 8'h29, 8'h28, 8'h11, 8'h10,
                 8'h00, 8'h01, 8'h00};
        repeat (2) @(posedge clk);
        #3 nrst = 1'b1;
        idle(1);
        chk("rst_win_ec", 32'(win_ec), 32'd239);
        chk("rst_win_ep", 32'(win_ep), 32'd319);
        chk("rst_pix", {pix_valid, pix_x, pix_y, pix_color}, 32'd0);

        seen.delete();
        cmd(8'h2C); dat(8'h08); dat(8'h14); idle(2);
        chk("s1_count", 32'(seen.size()), 32'd1);
        if (seen.size() > 0)
            chk("s1_pixel", {seen[0].x[7:0], seen[0].y[7:0], seen[0].c[15:0]},
                32'h0000_1408);

        window(20, 40, 60, 80);
        seen.delete();
        cmd(8'h2C); pixels(22); idle(2);
        chk("s2_win", {win_sc[7:0], win_ec[7:0], win_sp[7:0], win_ep[7:0]},
            32'h14283C50);
        chk("s2_count", 32'(seen.size()), 32'd22);
        for (int i = 0; i < 22 && i < seen.size(); i++)
            chk($sformatf("s2_addr%0d", i), 32'(seen[i].x * 1000 + seen[i].y),
                (i < 21) ? 32'((20 + i) * 1000 + 60) : 32'(20 * 1000 + 61));

        window(0, 1, 0, 1);
        seen.delete();
        cmd(8'h2C); pixels(5); idle(2);
        chk("s3_count", 32'(seen.size()), 32'd5);
        if (seen.size() == 5) begin
            chk("s3_a0", 32'(seen[0].x * 10 + seen[0].y), 32'd0);
            chk("s3_a1", 32'(seen[1].x * 10 + seen[1].y), 32'd10);
            chk("s3_a2", 32'(seen[2].x * 10 + seen[2].y), 32'd1);
            chk("s3_a3", 32'(seen[3].x * 10 + seen[3].y), 32'd11);
            chk("s3_a4", 32'(seen[4].x * 10 + seen[4].y), 32'd0);
        end

        do_reset();
        cmd(8'h2A); dat(8'h00); dat(8'h05); cmd(8'h29); idle(2);
        chk("s4_win_sc", 32'(win_sc), 32'd0);
        chk("s4_win_ec", 32'(win_ec), 32'd239);
        chk("s4_disp", 32'(disp_on), 32'd1);

        cmd(8'h11); cmd(8'h3A); dat(8'h55); idle(2);
        chk("s5_sleep", 32'(sleep_out), 32'd1);
        chk("s5_colmod", 32'(colmod), 32'h55);
        window(3, 9, 4, 7);
        cmd(8'h01); idle(2);
        chk("s5_swrst", {sleep_out, disp_on, colmod, win_sc[7:0], win_sp[7:0]}, 32'd0);
        chk("s5_swrst_end", {win_ec, win_ep}, {16'd239, 16'd319});
        bad_cnt = 0;
        cmd(8'hB7); idle(3);
        chk("s5_bad_once", 32'(bad_cnt), 32'd1);

        seen.delete();
        cmd(8'h2C); dat(8'hF8); cmd(8'h2C); dat(8'h1E); dat(8'h90); idle(2);
        chk("s6_count", 32'(seen.size()), 32'd1);
        if (seen.size() > 0)
            chk("s6_pixel", {seen[0].x[7:0], seen[0].y[7:0], seen[0].c[15:0]},
                32'h0000_901E);

        cmd(8'h2A); dat(8'h00); dat(8'h10); dat(8'h00);
        do_reset();
        dat(8'h11); idle(1);
        chk("rst_mid_win_sc", 32'(win_sc), 32'd0);
        chk("rst_mid_win_ec", 32'(win_ec), 32'd239);

        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (i % 900 == 450) do_reset();
            if (r < 15) idle(1);
            else if (r < 30) cmd(cmds[$urandom_range(0, 10)]);
            else if (r < 32) cmd(8'($urandom));
            else if (r < 55) dat(8'($urandom_range(0, 3)));
            else dat(8'($urandom));
        end
        idle(3);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
